// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline controller.
//   state_e          : FSM state encoding. The low two bits are what o_state
//                      reports. HALTED uses the third bit, so it reads as 0 on
//                      o_state and is flagged by o_halted.
//   DRAIN_CYCLES_DEF : default number of cycles for a halt to move from ID to WB.
package pipeline_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  localparam int unsigned DRAIN_CYCLES_DEF = 32'd3;

endpackage

// File: rtl/pipeline_ctrl.sv
// Run/step/halt controller for a five-stage pipeline.
// Converts debug commands and hazard-unit requests into the stage enables and
// flushes, and counts the cycles in which the pipeline advances.
//   i_clk, i_rst           : clock and asynchronous active-high reset
//   i_run, i_step, i_stop  : command pulses (free-run, single step, pause)
//   i_halt_id              : a halt instruction is in ID
//   i_hazard_stall/_flush  : load-use stall and branch/jump flush requests
//   o_pc_en, o_if_id_en    : front-end write enables
//   o_if_id_flush          : IF/ID bubble
//   o_id_ex_flush          : ID/EX bubble (control zeroed)
//   o_back_en              : ID/EX, EX/MEM and MEM/WB write enable
//   o_state, o_halted      : visible state (HALTED reads as 0 with o_halted=1)
//   o_cycle_cnt            : number of advancing cycles, wraps modulo 2^CNT_W
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_stop,
  input  logic             i_halt_id,
  input  logic             i_hazard_stall,
  input  logic             i_hazard_flush,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_back_en,
  output logic [1:0]       o_state,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  localparam int unsigned DCNT_W = (DRAIN_CYCLES < 32'd2) ? 32'd1 : $clog2(DRAIN_CYCLES + 32'd1);
  localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES);

  state_e             state_q, state_d;
  logic [DCNT_W-1:0]  drain_q, drain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               adv_s;

  // The pipeline moves in every state except IDLE and HALTED.
  assign adv_s = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);

  // Next-state and drain-counter logic.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (i_step) begin
          state_d = ST_STEP;
        end else if (i_run) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_halt_id) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (i_stop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP: begin
        if (i_halt_id) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // The counter holds the drain cycles still to go, this one included.
        if (drain_q <= DCNT_W'(1)) begin
          state_d = ST_HALTED;
          drain_d = '0;
        end else begin
          state_d = ST_DRAIN;
          drain_d = drain_q - DCNT_W'(1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
        drain_d = '0;
      end
    endcase
  end

  // Advancing-cycle counter.
  always_comb begin
    if (adv_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, drain-counter and cycle-counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage enables and flushes. A stall wins over a flush: the hazard unit
  // re-asserts the flush once the stall has cleared.
  always_comb begin
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    o_back_en     = 1'b0;
    if (!adv_s) begin
      o_pc_en = 1'b0;
    end else if (state_q == ST_DRAIN) begin
      // Fetch is frozen and bubbles are fed in behind the halt while the
      // halt and older instructions retire.
      o_pc_en       = 1'b0;
      o_if_id_en    = 1'b1;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b0;
      o_back_en     = 1'b1;
    end else begin
      o_pc_en       = ~i_hazard_stall;
      o_if_id_en    = ~i_hazard_stall;
      o_if_id_flush = i_hazard_flush & ~i_hazard_stall;
      o_id_ex_flush = i_hazard_stall;
      o_back_en     = 1'b1;
    end
  end

  assign o_state     = state_q[1:0];
  assign o_halted    = (state_q == ST_HALTED);
  assign o_cycle_cnt = cnt_q;

endmodule
